rv32i_mini_core: RTL and testbench

- Single-cycle RV32I subset core: PC register, 32-word instruction ROM, 32x32 register file, decoder, immediate sign-extender and 8-operation ALU.
- Executes one R-type or I-type ALU instruction per clock.
- ROM contents and initial register values arrive on array input ports.
- Internal datapath nets are exported on debug outputs for bench checking.

---
 rtl/rv32_pkg.sv | 46 ++++
 rtl/rv32_alu.sv | 26 ++
 rtl/rv32i_mini_core.sv | 115 +++++++++++
 tb/tb_rv32i_mini_core.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared types and decode constants for the rv32i mini core.
// The ALU op encoding is exported on a debug port, so its values are fixed.
package rv32_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SLT = 3'd7
  } alu_op_t;

  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_SUB = 7'b0100000;

  // funct3 011 and unrecognised codes decode to ADD.
  function automatic alu_op_t funct3_to_op(input logic [2:0] f3, input logic sub_sel);
    alu_op_t op;
    case (f3)
      F3_ADD:  op = sub_sel ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_XOR:  op = ALU_XOR;
      F3_SRL:  op = ALU_SRL;
      F3_OR:   op = ALU_OR;
      F3_AND:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32_alu.sv
// Combinational 8-operation ALU; shifts use only the low five bits of b.
module rv32_alu
  import rv32_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_t     alu_op,
  output logic [31:0] result
);

  always_comb begin
    result = a + b;
    case (alu_op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLL: result = a << b[4:0];
      ALU_SRL: result = a >> b[4:0];
      ALU_SLT: result = {31'd0, $signed(a) < $signed(b)};
      default: result = a + b;
    endcase
  end

endmodule

// File: rtl/rv32i_mini_core.sv
// Single-cycle RV32I ALU-subset core: ROM fetch, decode, regfile read, ALU and
// write-back all complete in one clock. Internal nets are exported for checking.
module rv32i_mini_core
  import rv32_pkg::*;
#(
  parameter int IMEM_WORDS = 32,
  parameter int XLEN       = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] initial_instructions [IMEM_WORDS-1:0],
  input  logic [XLEN-1:0] initial_register_values [31:0],
  output logic [XLEN-1:0] pc_out_check,
  output logic [XLEN-1:0] instruction_check,
  output logic [2:0]      alu_op_check,
  output logic [XLEN-1:0] register_data_out1_check,
  output logic [XLEN-1:0] register_data_out2_check,
  output logic [XLEN-1:0] b_input_check,
  output logic [XLEN-1:0] register_data_in_check,
  output logic [XLEN-1:0] alu_result_check,
  output logic            reg_write_check,
  output logic [XLEN-1:0] imm_ext_check,
  output logic            use_imm_check,
  output logic [XLEN-1:0] register_check [0:31]
);

  localparam int AW = $clog2(IMEM_WORDS);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] regs_q [32];
  logic [XLEN-1:0] regs_d [32];

  logic [XLEN-1:0] instr, imm_ext, rs1_data, rs2_data, b_in, alu_result;
  logic [6:0]      opcode, funct7;
  logic [4:0]      rd, rs1, rs2;
  logic [2:0]      funct3;
  logic            use_imm, reg_write;
  alu_op_t         alu_op;

  // Only the word-index bits address the ROM, so high PC bits alias back to word 0.
  always_comb begin
    instr   = initial_instructions[pc_q[AW+1:2]];
    opcode  = instr[6:0];
    rd      = instr[11:7];
    funct3  = instr[14:12];
    rs1     = instr[19:15];
    rs2     = instr[24:20];
    funct7  = instr[31:25];
    imm_ext = {{(XLEN-12){instr[31]}}, instr[31:20]};
  end

  always_comb begin
    alu_op    = ALU_ADD;
    use_imm   = 1'b0;
    reg_write = 1'b0;
    case (opcode)
      OP_REG: begin
        reg_write = 1'b1;
        alu_op    = funct3_to_op(funct3, funct7 == F7_SUB);
      end
      OP_IMM: begin
        reg_write = 1'b1;
        use_imm   = 1'b1;
        alu_op    = funct3_to_op(funct3, 1'b0);
      end
      default: ;
    endcase
  end

  always_comb begin
    rs1_data = (rs1 == 5'd0) ? '0 : regs_q[rs1];
    rs2_data = (rs2 == 5'd0) ? '0 : regs_q[rs2];
    b_in     = use_imm ? imm_ext : rs2_data;
  end

  rv32_alu u_alu (
    .a      (rs1_data),
    .b      (b_in),
    .alu_op (alu_op),
    .result (alu_result)
  );

  always_comb begin
    pc_d   = pc_q + 32'd4;
    regs_d = regs_q;
    if (reg_write && rd != 5'd0) regs_d[rd] = alu_result;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= '0;
      regs_q[0] <= '0;
      for (int i = 1; i < 32; i++) regs_q[i] <= initial_register_values[i];
    end else begin
      pc_q   <= pc_d;
      regs_q <= regs_d;
    end
  end

  always_comb begin
    pc_out_check             = pc_q;
    instruction_check        = instr;
    alu_op_check             = alu_op;
    register_data_out1_check = rs1_data;
    register_data_out2_check = rs2_data;
    b_input_check            = b_in;
    register_data_in_check   = alu_result;
    alu_result_check         = alu_result;
    reg_write_check          = reg_write;
    imm_ext_check            = imm_ext;
    use_imm_check            = use_imm;
    for (int i = 0; i < 32; i++) register_check[i] = (i == 0) ? '0 : regs_q[i];
  end

endmodule

// File: tb/tb_rv32i_mini_core.sv
// Bench for rv32i_mini_core: directed program from the test plan, ALU unit
// vectors, and random programs checked against an instruction-level model.
module tb_rv32i_mini_core;
  import rv32_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] rom [31:0];
  logic [31:0] init_regs [31:0];
  logic [31:0] pc_o, instr_o, rd1_o, rd2_o, b_o, wd_o, res_o, imm_o;
  logic [2:0]  op_o;
  logic        we_o, ui_o;
  logic [31:0] rchk [0:31];

  logic [31:0] ta, tb;
  alu_op_t     top;
  logic [31:0] tr;

  int checks = 0;
  int errors = 0;

  // model state
  logic [31:0] mregs [32];
  logic [31:0] mpc;

  always #5 clk = ~clk;

  rv32i_mini_core #(.IMEM_WORDS(32), .XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .initial_instructions(rom), .initial_register_values(init_regs),
    .pc_out_check(pc_o), .instruction_check(instr_o), .alu_op_check(op_o),
    .register_data_out1_check(rd1_o), .register_data_out2_check(rd2_o),
    .b_input_check(b_o), .register_data_in_check(wd_o), .alu_result_check(res_o),
    .reg_write_check(we_o), .imm_ext_check(imm_o), .use_imm_check(ui_o),
    .register_check(rchk)
  );

  rv32_alu u_alu_chk (.a(ta), .b(tb), .alu_op(top), .result(tr));

  // Instruction-level reference: what the ISA says this word does to the state.
  function automatic void ref_exec(input logic [31:0] ins, output logic we,
                                   output logic ui, output logic [31:0] res);
    logic [31:0] a, b;
    logic        isr, isi;
    isr = ins[6:0] == 7'h33;
    isi = ins[6:0] == 7'h13;
    a   = mregs[ins[19:15]];
    b   = isi ? {{20{ins[31]}}, ins[31:20]} : mregs[ins[24:20]];
    we  = isr || isi;
    ui  = isi;
    res = a + b;
    if (we) begin
      case (ins[14:12])
        3'd0: res = (isr && ins[31:25] == 7'h20) ? a - b : a + b;
        3'd1: res = a << b[4:0];
        3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        3'd4: res = a ^ b;
        3'd5: res = a >> b[4:0];
        3'd6: res = a | b;
        3'd7: res = a & b;
        default: res = a + b;
      endcase
    end
  endfunction

  task automatic model_edge(input logic rst);
    logic we, ui;
    logic [31:0] res;
    if (rst) begin
      mpc = 0;
      for (int i = 0; i < 32; i++) mregs[i] = (i == 0) ? 32'd0 : init_regs[i];
    end else begin
      ref_exec(rom[mpc[6:2]], we, ui, res);
      if (we && rom[mpc[6:2]][11:7] != 5'd0) mregs[rom[mpc[6:2]][11:7]] = res;
      mpc = mpc + 4;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_alu_unit();
    logic [31:0] exp_t [8];
    exp_t = '{32'd6, 32'd2, 32'd0, 32'd6, 32'd6, 32'd16, 32'd1, 32'd0};
    ta = 32'd4; tb = 32'd2;
    for (int i = 0; i < 8; i++) begin
      top = alu_op_t'(i);
      #1;
      checks++;
      if (tr !== exp_t[i]) begin
        errors++;
        $display("FAIL alu_op%0d: got %0d expected %0d", i, tr, exp_t[i]);
      end
    end
    ta = 32'hFFFF_FFFF; tb = 32'd1; top = ALU_SLT;
    #1;
    checks++;
    if (tr !== 32'd1) begin
      errors++;
      $display("FAIL alu_slt_neg: got %0d expected 1", tr);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 32; i++) begin
      rom[i] = 32'd0;
      init_regs[i] = 32'd3000 + i;
    end
    rom[0] = 32'h005303b3;
    rom[1] = 32'h40848533;
    rom[2] = 32'h00160693;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (pc_o !== 32'd0) begin errors++; $display("FAIL rst_pc: got %0h expected 0", pc_o); end
    checks++; if (instr_o !== 32'h005303b3) begin errors++; $display("FAIL rst_instr: got %h expected 005303b3", instr_o); end
    checks++; if (op_o !== 3'd0) begin errors++; $display("FAIL rst_op: got %0d expected 0", op_o); end
    checks++; if (rd1_o !== 32'd3006) begin errors++; $display("FAIL rst_rd1: got %0d expected 3006", rd1_o); end
    checks++; if (rd2_o !== 32'd3005) begin errors++; $display("FAIL rst_rd2: got %0d expected 3005", rd2_o); end
    checks++; if (res_o !== 32'd6011) begin errors++; $display("FAIL rst_res: got %0d expected 6011", res_o); end
    checks++; if (ui_o !== 1'b0 || we_o !== 1'b1) begin errors++; $display("FAIL rst_ctl: got ui=%b we=%b expected ui=0 we=1", ui_o, we_o); end
    checks++; if (rchk[0] !== 32'd0 || rchk[31] !== 32'd3031) begin errors++; $display("FAIL rst_regs: got x0=%0d x31=%0d expected 0 3031", rchk[0], rchk[31]); end
  endtask

  task automatic test_program();
    logic [31:0] snap [0:31];
    int n;
    tick();
    checks++; if (rchk[7] !== 32'd6011) begin errors++; $display("FAIL x7: got %0d expected 6011", rchk[7]); end
    checks++; if (pc_o !== 32'd4) begin errors++; $display("FAIL pc4: got %0d expected 4", pc_o); end
    checks++; if (op_o !== 3'd1) begin errors++; $display("FAIL sub_op: got %0d expected 1", op_o); end
    checks++; if (rd1_o !== 32'd3009 || rd2_o !== 32'd3008) begin errors++; $display("FAIL sub_rd: got %0d %0d expected 3009 3008", rd1_o, rd2_o); end
    checks++; if (res_o !== 32'd1) begin errors++; $display("FAIL sub_res: got %0d expected 1", res_o); end
    tick();
    checks++; if (rchk[10] !== 32'd1 || pc_o !== 32'd8) begin errors++; $display("FAIL x10: got x10=%0d pc=%0d expected 1 8", rchk[10], pc_o); end
    checks++; if (op_o !== 3'd0 || ui_o !== 1'b1 || imm_o !== 32'd1 || b_o !== 32'd1) begin
      errors++; $display("FAIL addi_dec: got op=%0d ui=%b imm=%0d b=%0d expected 0 1 1 1", op_o, ui_o, imm_o, b_o); end
    checks++; if (rd1_o !== 32'd3012 || res_o !== 32'd3013 || wd_o !== 32'd3013) begin
      errors++; $display("FAIL addi_res: got rd1=%0d res=%0d wd=%0d expected 3012 3013 3013", rd1_o, res_o, wd_o); end
    tick();
    checks++; if (rchk[13] !== 32'd3013) begin errors++; $display("FAIL x13: got %0d expected 3013", rchk[13]); end
    checks++; if (pc_o !== 32'd12 || we_o !== 1'b0) begin errors++; $display("FAIL nop: got pc=%0d we=%b expected 12 0", pc_o, we_o); end
    snap = rchk;
    tick();
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (rchk[i] !== snap[i]) begin errors++; $display("FAIL nop_x%0d: got %0d expected %0d", i, rchk[i], snap[i]); end
    end
    n = 0;
    while (pc_o !== 32'd128 && n < 40) begin tick(); n++; end
    checks++; if (pc_o !== 32'd128 || instr_o !== 32'h005303b3) begin
      errors++; $display("FAIL wrap: got pc=%0d instr=%h expected 128 005303b3", pc_o, instr_o); end
  endtask

  task automatic test_neg_imm();
    rom[0] = 32'hFFF10093; // addi x1, x2, -1
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (imm_o !== 32'hFFFF_FFFF || b_o !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL neg_imm: got imm=%h b=%h expected ffffffff", imm_o, b_o); end
    checks++; if (res_o !== 32'd3001) begin errors++; $display("FAIL neg_imm_res: got %0d expected 3001", res_o); end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  f7;
    w = $urandom;
    case ($urandom_range(0, 5))
      0, 1: begin
        f7 = ($urandom_range(0, 2) == 0) ? w[31:25] : (w[31] ? 7'h20 : 7'h00);
        w = {f7, w[24:7], 7'h33};
      end
      2, 3: w = {w[31:7], 7'h13};
      4: w = 32'd0;
      default: if (w[6:0] == 7'h33 || w[6:0] == 7'h13) w[6:0] = 7'h03;
    endcase
    if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  task automatic test_random();
    logic we, ui;
    logic [31:0] res;
    for (int i = 0; i < 32; i++) begin
      rom[i] = rand_instr();
      init_regs[i] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
    end
    reset = 1'b1; tick(); reset = 1'b0;
    model_edge(1'b1);
    for (int c = 0; c < 150; c++) begin
      if (c == 75) begin
        for (int i = 0; i < 32; i++) init_regs[i] = $urandom;
        reset = 1'b1;
      end
      ref_exec(rom[mpc[6:2]], we, ui, res);
      checks++;
      if (pc_o !== mpc || instr_o !== rom[mpc[6:2]]) begin
        errors++; $display("FAIL rnd_fetch c%0d: got pc=%h instr=%h expected %h %h", c, pc_o, instr_o, mpc, rom[mpc[6:2]]); end
      checks++;
      if (res_o !== res || we_o !== we || ui_o !== ui) begin
        errors++; $display("FAIL rnd_exec c%0d: got res=%h we=%b ui=%b expected %h %b %b", c, res_o, we_o, ui_o, res, we, ui); end
      tick();
      model_edge(reset);
      reset = 1'b0;
      for (int i = 0; i < 32; i++) begin
        checks++;
        if (rchk[i] !== mregs[i]) begin errors++; $display("FAIL rnd_x%0d c%0d: got %h expected %h", i, c, rchk[i], mregs[i]); end
      end
      checks++;
      if (pc_o !== mpc) begin errors++; $display("FAIL rnd_pc c%0d: got %h expected %h", c, pc_o, mpc); end
    end
  endtask

  initial begin
    ta = 0; tb = 0; top = ALU_ADD;
    for (int i = 0; i < 32; i++) begin rom[i] = 0; init_regs[i] = 0; end
    test_alu_unit();
    test_reset();
    test_program();
    test_neg_imm();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
